// File: rtl/proc_trace_monitor_pkg.sv
// Shared definitions for the processor trace monitor: FSM encoding and trace entry layout.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package proc_trace_monitor_pkg;

    // Sequencer phases: idle, processor held in reset, processor running, run finished.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Trace entry layout, LSB first: timestamp, channel index, logged value.
    // A packed struct cannot carry the module parameters, so the layout is
    // expressed as field offsets shared by the writer and the reader.
    function automatic int entry_width(input int data_w, input int ch_w, input int ts_w);
        return data_w + ch_w + ts_w;
    endfunction

    function automatic int entry_ts_lsb();
        return 0;
    endfunction

    function automatic int entry_ch_lsb(input int ts_w);
        return ts_w;
    endfunction

    function automatic int entry_data_lsb(input int ch_w, input int ts_w);
        return ch_w + ts_w;
    endfunction

endpackage

// File: rtl/proc_trace_monitor_trace_fifo.sv
// Trace buffer: DEPTH-entry FIFO with a registered head entry (show-ahead).
// Latency: an entry pushed into an empty buffer is visible at the head one cycle after the push edge.
// Backpressure: push is dropped while full (fullness taken before any same-cycle pop); head holds while not popped.
//
// Ports: clk, rst_n (async active-low), clear (synchronous flush), push/push_data/full (write side),
//        pop/head_valid/head_data (read side). DEPTH must be a power of two, at least 2.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so that full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_nxt;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] head_nxt;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push    = push && !full && !clear;
    assign do_pop     = pop && !empty;
    assign rd_ptr_nxt = rd_ptr + PTR_ONE;
    assign head_valid = !empty;

    // The head register follows the read pointer. When the slot behind the
    // head is being written in the same cycle, forward the incoming data.
    always_comb begin
        head_nxt = head_data;
        if (do_pop) begin
            if (do_push && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0])) begin
                head_nxt = push_data;
            end else begin
                head_nxt = mem[rd_ptr_nxt[AW-1:0]];
            end
        end else if (empty && do_push) begin
            head_nxt = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            head_data <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            head_data <= head_nxt;
        end
    end

endmodule

// File: rtl/proc_trace_monitor.sv
// Runs a processor through reset+run and logs changes of watched registers into a trace buffer.
// Latency: a change seen in RUN cycle ts is pushed at the end of that cycle and readable the next cycle.
// Backpressure: rd_valid/rd_ready; a full buffer defers the change (baseline kept) and sets sticky overflow.
//
// Ports: clk, global_reset (async active-low), start (one-cycle request),
//        core_reset/core_run (processor control), watch_data (NUM_CH x DATA_W, ch0 in LSBs),
//        rd_valid/rd_ready/rd_data/rd_ch/rd_ts (trace read side), overflow (sticky), done.
module proc_trace_monitor
    import proc_trace_monitor_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int NUM_CH       = 4,
    parameter int DEPTH        = 16,
    parameter int TS_W         = 16,
    parameter int RESET_CYCLES = 2,
    parameter int RUN_CYCLES   = 30
) (
    input  logic                       clk,
    input  logic                       global_reset,
    input  logic                       start,
    output logic                       core_reset,
    output logic                       core_run,
    input  logic [NUM_CH*DATA_W-1:0]   watch_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_W-1:0]          rd_data,
    output logic [ch_width(NUM_CH)-1:0] rd_ch,
    output logic [TS_W-1:0]            rd_ts,
    output logic                       overflow,
    output logic                       done
);
    localparam int CH_W     = ch_width(NUM_CH);
    localparam int EW       = entry_width(DATA_W, CH_W, TS_W);
    localparam int TS_LSB   = entry_ts_lsb();
    localparam int CH_LSB   = entry_ch_lsb(TS_W);
    localparam int DATA_LSB = entry_data_lsb(CH_W, TS_W);
    localparam int PH_MAX   = (RESET_CYCLES > RUN_CYCLES) ? RESET_CYCLES : RUN_CYCLES;
    localparam int PH_W     = $clog2(PH_MAX + 1);

    state_t            state_q;
    state_t            state_d;
    logic [PH_W-1:0]   phase_q;
    logic [PH_W-1:0]   phase_d;
    logic              start_acc;
    logic [TS_W-1:0]   ts_q;

    logic [DATA_W-1:0] watch_ch [NUM_CH];
    logic [DATA_W-1:0] base_q   [NUM_CH];
    logic [NUM_CH-1:0] diff;
    logic [CH_W-1:0]   sel;
    logic              first_run_cycle;
    logic              log_cand;
    logic              fifo_full;
    logic              fifo_push;
    logic [EW-1:0]     push_entry;
    logic [EW-1:0]     head_entry;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_watch
        assign watch_ch[g] = watch_data[g*DATA_W +: DATA_W];
    end

    // Sequencer: start is honoured only from IDLE or DONE; the phase counter
    // times the RST and RUN dwell and restarts from zero on each transition.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        start_acc  = 1'b0;
        core_reset = 1'b0;
        core_run   = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = ST_RST;
                    phase_d   = '0;
                end
            end
            ST_RST: begin
                core_reset = 1'b1;
                if (phase_q == PH_W'(RESET_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_RUN: begin
                core_run = 1'b1;
                if (phase_q == PH_W'(RUN_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = ST_RST;
                    phase_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Timestamp counts RUN cycles from zero; it is the ts of the current cycle.
    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            ts_q <= '0;
        end else if (start_acc) begin
            ts_q <= '0;
        end else if (core_run) begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // The first RUN cycle only captures baselines. Tracked by the phase
    // counter rather than ts so a wrapped timestamp cannot retrigger it.
    assign first_run_cycle = core_run && (phase_q == '0);

    // Lowest-index differing channel wins; the others stay different from
    // their baseline and are picked up again on a later cycle.
    always_comb begin
        diff = '0;
        sel  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            diff[c] = (watch_ch[c] != base_q[c]);
        end
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (diff[c]) begin
                sel = CH_W'(c);
            end
        end
    end

    assign log_cand  = core_run && !first_run_cycle && (|diff);
    assign fifo_push = log_cand && !fifo_full;

    always_comb begin
        push_entry                        = '0;
        push_entry[TS_LSB +: TS_W]        = ts_q;
        push_entry[CH_LSB +: CH_W]        = sel;
        push_entry[DATA_LSB +: DATA_W]    = watch_ch[sel];
    end

    // A baseline only advances when its change actually made it into the
    // buffer, so a deferred change is retried with the then-current value.
    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                base_q[c] <= '0;
            end
        end else if (first_run_cycle) begin
            for (int c = 0; c < NUM_CH; c++) begin
                base_q[c] <= watch_ch[c];
            end
        end else if (fifo_push) begin
            base_q[sel] <= watch_ch[sel];
        end
    end

    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            overflow <= 1'b0;
        end else if (start_acc) begin
            overflow <= 1'b0;
        end else if (log_cand && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .clk        (clk),
        .rst_n      (global_reset),
        .clear      (start_acc),
        .push       (fifo_push),
        .push_data  (push_entry),
        .full       (fifo_full),
        .pop        (rd_ready),
        .head_valid (rd_valid),
        .head_data  (head_entry)
    );

    assign rd_ts   = head_entry[TS_LSB +: TS_W];
    assign rd_ch   = head_entry[CH_LSB +: CH_W];
    assign rd_data = head_entry[DATA_LSB +: DATA_W];

endmodule

// File: tb/tb_proc_trace_monitor.sv
module tb_proc_trace_monitor;
    localparam int DW   = 32;
    localparam int NCH  = 4;
    localparam int DEP  = 16;
    localparam int TSW  = 16;
    localparam int RSTC = 2;
    localparam int RUNC = 30;
    localparam int CHW  = 2;

    logic             clk = 1'b0;
    logic             global_reset;
    logic             start;
    logic             core_reset;
    logic             core_run;
    logic [NCH*DW-1:0] watch_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [DW-1:0]    rd_data;
    logic [CHW-1:0]   rd_ch;
    logic [TSW-1:0]   rd_ts;
    logic             overflow;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: run position counted in cycles since the accepted start,
    // trace buffer as a queue of entries.
    typedef struct {
        logic [DW-1:0]  data;
        logic [CHW-1:0] ch;
        logic [TSW-1:0] ts;
    } ent_t;

    ent_t          m_q[$];
    bit            m_active;
    int            m_k;
    logic [DW-1:0] m_base [NCH];
    bit            m_ovf;

    proc_trace_monitor #(
        .DATA_W(DW), .NUM_CH(NCH), .DEPTH(DEP), .TS_W(TSW),
        .RESET_CYCLES(RSTC), .RUN_CYCLES(RUNC)
    ) dut (
        .clk(clk), .global_reset(global_reset), .start(start),
        .core_reset(core_reset), .core_run(core_run), .watch_data(watch_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_ch(rd_ch), .rd_ts(rd_ts), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_q.delete();
        m_active = 0;
        m_k      = 0;
        m_ovf    = 0;
        for (int c = 0; c < NCH; c++) m_base[c] = '0;
    endtask

    task automatic set_ch(input int c, input logic [DW-1:0] v);
        watch_data[c*DW +: DW] = v;
    endtask

    // Advance the model over one clock edge using the current inputs, then
    // let the DUT take the same edge; outputs are sampled 1 time unit later.
    task automatic tick();
        bit   in_run;
        bit   was_full;
        bit   do_pop;
        int   ts;
        int   pick;
        ent_t e;
        do_pop   = (m_q.size() > 0) && rd_ready;
        was_full = (m_q.size() >= DEP);
        in_run   = m_active && (m_k >= RSTC) && (m_k < RSTC + RUNC);
        pick     = -1;
        if (in_run) begin
            ts = m_k - RSTC;
            if (ts == 0) begin
                for (int c = 0; c < NCH; c++) m_base[c] = watch_data[c*DW +: DW];
            end else begin
                for (int c = NCH - 1; c >= 0; c--)
                    if (watch_data[c*DW +: DW] != m_base[c]) pick = c;
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (pick >= 0) begin
            if (!was_full) begin
                e.data = watch_data[pick*DW +: DW];
                e.ch   = CHW'(pick);
                e.ts   = TSW'(ts);
                m_q.push_back(e);
                m_base[pick] = e.data;
            end else begin
                m_ovf = 1;
            end
        end
        if (start && (!m_active || m_k == RSTC + RUNC)) begin
            m_q.delete();
            m_ovf    = 0;
            m_active = 1;
            m_k      = 0;
        end else if (m_active && m_k < RSTC + RUNC) begin
            m_k++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic finish_run();
        while (m_active && m_k < RSTC + RUNC) tick();
    endtask

    task automatic test_reset();
        global_reset = 1'b1;
        start        = 1'b0;
        rd_ready     = 1'b0;
        watch_data   = '0;
        model_reset();
        #3 global_reset = 1'b0;
        #1;
        n_cmp++;
        if ({core_reset, core_run, done} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got rst/run/done=%b required 000", {core_reset, core_run, done});
        end
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rd_valid: got %b required 0", rd_valid);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_overflow: got %b required 0", overflow);
        end
        repeat (2) @(posedge clk);
        #1 global_reset = 1'b1;
        tick();
        n_cmp++;
        if ({core_reset, core_run, done, rd_valid} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_idle: got %b required 0000", {core_reset, core_run, done, rd_valid});
        end
    endtask

    task automatic test_sequencing();
        int n_rst     = 0;
        int n_run     = 0;
        int first_run = -1;
        int done_at   = -1;
        watch_data = '0;
        rd_ready   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (core_reset) n_rst++;
            if (core_run) begin
                n_run++;
                if (first_run < 0) first_run = i;
            end
            if (done && done_at < 0) done_at = i;
            start = (i == 10);   // a start during RUN must be ignored
            tick();
        end
        start = 1'b0;
        n_cmp++;
        if (n_rst != RSTC) begin
            n_bad++;
            $display("FAIL seq_reset_len: got %0d cycles required %0d", n_rst, RSTC);
        end
        n_cmp++;
        if (n_run != RUNC) begin
            n_bad++;
            $display("FAIL seq_run_len: got %0d cycles required %0d", n_run, RUNC);
        end
        n_cmp++;
        if (first_run != RSTC) begin
            n_bad++;
            $display("FAIL seq_run_start: got cycle %0d required %0d", first_run, RSTC);
        end
        n_cmp++;
        if (done_at != RSTC + RUNC || done !== 1'b1) begin
            n_bad++;
            $display("FAIL seq_done: got first done at %0d (done=%b) required %0d (1)", done_at, done, RSTC + RUNC);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({core_reset, done} !== 2'b10) begin
            n_bad++;
            $display("FAIL seq_restart: got rst/done=%b required 10", {core_reset, done});
        end
    endtask

    task automatic test_logging();
        finish_run();
        watch_data = '0;
        rd_ready   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (RSTC + 3) tick();   // now in the ts=3 cycle
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL log_idle_before: got rd_valid=%b required 0", rd_valid);
        end
        set_ch(1, 32'd5);
        tick();
        n_cmp++;
        if (rd_valid !== 1'b1 || {rd_data, rd_ch, rd_ts} !== {32'd5, 2'd1, 16'd3}) begin
            n_bad++;
            $display("FAIL log_entry: got v=%b {%0d,ch%0d,ts%0d} required v=1 {5,ch1,ts3}", rd_valid, rd_data, rd_ch, rd_ts);
        end
        tick();
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL log_single: got rd_valid=%b required 0", rd_valid);
        end
    endtask

    task automatic test_arbitration();
        finish_run();
        watch_data = '0;
        rd_ready   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (RSTC + 4) tick();   // ts=4 cycle
        set_ch(0, 32'd7);
        set_ch(2, 32'd9);
        tick();
        n_cmp++;
        if (rd_valid !== 1'b1 || {rd_data, rd_ch, rd_ts} !== {32'd7, 2'd0, 16'd4}) begin
            n_bad++;
            $display("FAIL arb_first: got v=%b {%0d,ch%0d,ts%0d} required v=1 {7,ch0,ts4}", rd_valid, rd_data, rd_ch, rd_ts);
        end
        tick();
        rd_ready = 1'b1;
        tick();
        n_cmp++;
        if (rd_valid !== 1'b1 || {rd_data, rd_ch, rd_ts} !== {32'd9, 2'd2, 16'd5}) begin
            n_bad++;
            $display("FAIL arb_second: got v=%b {%0d,ch%0d,ts%0d} required v=1 {9,ch2,ts5}", rd_valid, rd_data, rd_ch, rd_ts);
        end
        tick();
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL arb_count: got rd_valid=%b required 0", rd_valid);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0]  exp_d;
        logic [TSW-1:0] exp_t;
        finish_run();
        watch_data = '0;
        rd_ready   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (RSTC + 1) tick();   // ts=1 cycle
        for (int t = 1; t <= DEP + 1; t++) begin
            set_ch(0, DW'(100 + t));
            if (t == DEP + 1) begin
                n_cmp++;
                if (overflow !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ovf_early: got overflow=%b required 0 with %0d entries", overflow, DEP);
                end
            end
            tick();
        end
        n_cmp++;
        if (overflow !== 1'b1 || rd_valid !== 1'b1 || {rd_data, rd_ts} !== {32'd101, 16'd1}) begin
            n_bad++;
            $display("FAIL ovf_set: got ovf=%b v=%b {%0d,ts%0d} required ovf=1 v=1 {101,ts1}", overflow, rd_valid, rd_data, rd_ts);
        end
        rd_ready = 1'b1;
        tick();             // one pop at the ts=18 edge, push still blocked
        rd_ready = 1'b0;
        tick();             // deferred change logged at ts=19
        rd_ready = 1'b1;
        for (int i = 0; i < DEP; i++) begin
            exp_d = (i < DEP - 1) ? DW'(102 + i) : 32'd117;
            exp_t = (i < DEP - 1) ? TSW'(2 + i) : 16'd19;
            n_cmp++;
            if (rd_valid !== 1'b1 || {rd_data, rd_ch, rd_ts} !== {exp_d, 2'd0, exp_t}) begin
                n_bad++;
                $display("FAIL ovf_drain[%0d]: got v=%b {%0d,ch%0d,ts%0d} required v=1 {%0d,ch0,ts%0d}", i, rd_valid, rd_data, rd_ch, rd_ts, exp_d, exp_t);
            end
            tick();
        end
        n_cmp++;
        if (rd_valid !== 1'b0 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_end: got v=%b ovf=%b required v=0 ovf=1", rd_valid, overflow);
        end
    endtask

    task automatic test_back_to_back();
        bit                    stall;
        logic [DW+CHW+TSW-1:0] prev;
        finish_run();
        watch_data = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            rd_ready = i[0];
            if ($urandom_range(0, 1) == 0) set_ch($urandom_range(0, NCH - 1), DW'($urandom_range(0, 3)));
            stall = rd_valid && !rd_ready;
            prev  = {rd_data, rd_ch, rd_ts};
            tick();
            if (stall) begin
                n_cmp++;
                if (rd_valid !== 1'b1 || {rd_data, rd_ch, rd_ts} !== prev) begin
                    n_bad++;
                    $display("FAIL b2b_stable cycle %0d: got v=%b %h required v=1 %h", i, rd_valid, {rd_data, rd_ch, rd_ts}, prev);
                end
            end
            n_cmp++;
            if (rd_valid !== (m_q.size() > 0)) begin
                n_bad++;
                $display("FAIL b2b_valid cycle %0d: got %b required %b", i, rd_valid, m_q.size() > 0);
            end
            if (m_q.size() > 0) begin
                n_cmp++;
                if ({rd_data, rd_ch, rd_ts} !== {m_q[0].data, m_q[0].ch, m_q[0].ts}) begin
                    n_bad++;
                    $display("FAIL b2b_order cycle %0d: got {%0d,ch%0d,ts%0d} required {%0d,ch%0d,ts%0d}", i, rd_data, rd_ch, rd_ts, m_q[0].data, m_q[0].ch, m_q[0].ts);
                end
            end
        end
    endtask

    task automatic test_random();
        bit exp_rst, exp_run, exp_done;
        for (int i = 0; i < 400; i++) begin
            start    = ($urandom_range(0, 39) == 0);
            rd_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) != 0) set_ch($urandom_range(0, NCH - 1), DW'($urandom_range(0, 3)));
            tick();
            exp_rst  = m_active && (m_k < RSTC);
            exp_run  = m_active && (m_k >= RSTC) && (m_k < RSTC + RUNC);
            exp_done = m_active && (m_k == RSTC + RUNC);
            n_cmp++;
            if ({core_reset, core_run, done, rd_valid, overflow} !== {exp_rst, exp_run, exp_done, m_q.size() > 0, m_ovf}) begin
                n_bad++;
                $display("FAIL rand_ctrl cycle %0d: got rst/run/done/v/ovf=%b required %b", i,
                         {core_reset, core_run, done, rd_valid, overflow}, {exp_rst, exp_run, exp_done, m_q.size() > 0, m_ovf});
            end
            if (m_q.size() > 0) begin
                n_cmp++;
                if ({rd_data, rd_ch, rd_ts} !== {m_q[0].data, m_q[0].ch, m_q[0].ts}) begin
                    n_bad++;
                    $display("FAIL rand_head cycle %0d: got {%0d,ch%0d,ts%0d} required {%0d,ch%0d,ts%0d}", i, rd_data, rd_ch, rd_ts, m_q[0].data, m_q[0].ch, m_q[0].ts);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        finish_run();
        watch_data = '0;
        rd_ready   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (RSTC + 1) tick();
        for (int t = 1; t < 10; t++) begin
            set_ch(3, DW'(t));
            tick();
        end
        n_cmp++;
        if (core_run !== 1'b1 || rd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre: got run=%b v=%b required 1 1", core_run, rd_valid);
        end
        #2 global_reset = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({core_reset, core_run, done, rd_valid, overflow} !== 5'b00000) begin
            n_bad++;
            $display("FAIL mid_async: got rst/run/done/v/ovf=%b required 00000", {core_reset, core_run, done, rd_valid, overflow});
        end
        @(posedge clk);
        #1 global_reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({core_reset, core_run, done, rd_valid, overflow} !== 5'b00000) begin
            n_bad++;
            $display("FAIL mid_idle: got rst/run/done/v/ovf=%b required 00000", {core_reset, core_run, done, rd_valid, overflow});
        end
    endtask

    initial begin
        test_reset();
        test_sequencing();
        test_logging();
        test_arbitration();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/proc_trace_monitor.md
PROC_TRACE_MONITOR -- requirements
Module: proc_trace_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each watched register.
REQ-002 SHALL have parameter NUM_CH, default 4, number of watched registers (channels), minimum 1.
REQ-003 SHALL have parameter DEPTH, default 16, trace buffer entries, power of two.
REQ-004 SHALL have parameter TS_W, default 16, timestamp width.
REQ-005 SHALL have parameter RESET_CYCLES, default 2, cycles core_reset is held asserted.
REQ-006 SHALL have parameter RUN_CYCLES, default 30, cycles core_run stays asserted per run.
REQ-007 SHALL have port clk  input  1  single system clock, rising edge.
REQ-008 SHALL have port global_reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port start  input  1  one-cycle request to begin a reset+run sequence.
REQ-010 SHALL have port core_reset  output  1  active-high reset to the processor top.
REQ-011 SHALL have port core_run  output  1  processor clock enable.
REQ-012 SHALL have port watch_data  input  NUM_CH*DATA_W  watched register values, channel 0 in the LSBs.
REQ-013 SHALL have port rd_valid  output  1  trace entry available.
REQ-014 SHALL have port rd_ready  input  1  consumer accepts the entry.
REQ-015 SHALL have port rd_data  output  DATA_W  logged value.
REQ-016 SHALL have port rd_ch  output  max(1,clog2(NUM_CH))  logged channel index.
REQ-017 SHALL have port rd_ts  output  TS_W  run-cycle timestamp of the entry.
REQ-018 SHALL have port overflow  output  1  sticky: a change was delayed by a full buffer.
REQ-019 SHALL have port done  output  1  run finished.

Function
REQ-020 SHALL implement FSM IDLE -> RST -> RUN -> DONE; start in IDLE or DONE -> RST; start in RST or RUN is ignored.
REQ-021 SHALL assert core_reset only in RST, for exactly RESET_CYCLES cycles, then enter RUN.
REQ-022 SHALL assert core_run only in RUN, for exactly RUN_CYCLES cycles, then enter DONE; done is high only in DONE.
REQ-023 SHALL, on accepted start, clear buffer, overflow and timestamp counter in the same edge.
REQ-024 SHALL increment the timestamp each RUN cycle from 0, wrapping at 2^TS_W.
REQ-025 SHALL, in the first RUN cycle (ts=0), load a per-channel baseline from watch_data without logging.
REQ-026 SHALL, in each later RUN cycle, select the lowest-index channel whose watch_data differs from its baseline; if the buffer is not full, push {value, channel, ts} and update that baseline.
REQ-027 SHALL log at most one entry per cycle; other differing channels are retried next cycle with their then-current value.
REQ-028 SHALL, when a change is pending and the buffer is full, not push, not update the baseline, and set overflow.
REQ-029 SHALL decide fullness before the same-cycle pop: push is blocked when count==DEPTH, even if a pop occurs.
REQ-030 SHALL pop on rd_valid && rd_ready; rd_data/rd_ch/rd_ts SHALL be stable while rd_valid && !rd_ready.
REQ-031 SHALL present a pushed entry with rd_valid one cycle after the push edge (empty buffer).
REQ-032 SHALL allow reads in every state; no logging outside RUN.
REQ-033 SHALL wrap read/write pointers modulo DEPTH; an extra pointer bit distinguishes full from empty.

Reset
REQ-034 SHALL, on global_reset low, immediately enter IDLE: core_reset=0, core_run=0, done=0, rd_valid=0, overflow=0, buffer empty, timestamp 0, baselines 0.
REQ-035 SHALL abort a run in progress on reset; no partial entry remains.

Structure
REQ-036 SHALL place the FSM state encoding and the entry-field layout in the shared package.
REQ-037 SHALL instantiate one sub-module, trace_fifo (DEPTH x (DATA_W+ch+TS_W), registered head).

Verification
REQ-038 SHALL check sequencing: start pulse -> core_reset high 2 cycles, core_run high 30 cycles, then done=1.
REQ-039 SHALL check logging: ch1 changes 0 -> 5 at ts=3, rd_ready=1 -> one entry {5, ch1, ts=3}, rd_valid one cycle later.
REQ-040 SHALL check arbitration: ch0 and ch2 change together at ts=4 -> entries {ch0, ts=4}, {ch2, ts=5}.
REQ-041 SHALL check overflow: rd_ready=0, DEPTH+1 distinct changes on ch0 -> 16 entries, overflow=1, 17th logged after one pop.
REQ-042 SHALL check back-pressure: rd_ready toggled each cycle -> outputs stable while stalled, order preserved.
REQ-043 SHALL check reset mid-RUN: global_reset low at ts=10 -> IDLE, rd_valid=0, core_run=0 asynchronously.
